// File: rtl/reg_pipeline_pkg.sv
// Shared constants and helpers for the reg_pipeline delay line.
package reg_pipeline_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Width needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipeline_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
// Priority is rst > flush > en > hold. Flush clears only the valid bit.
module reg_stage
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d  = d_i;
            valid_d = valid_i;
        end
        // Data keeps following en during a flush; only validity is dropped.
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o     = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_pipeline.sv
// WIDTH-bit, DEPTH-stage register pipeline with valid tracking, flush and Qn.
// Optional occupancy counter enabled by defining REG_PIPELINE_OCCUPANCY_EN.
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
`ifdef REG_PIPELINE_OCCUPANCY_EN
    output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Q_valid
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (gi == 0) begin : g_head
            assign d_in = D;
            assign v_in = D_valid;
        end else begin : g_link
            assign d_in = stage_data[gi-1];
            assign v_in = stage_valid[gi-1];
        end

        reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .flush   (flush),
            .d_i     (d_in),
            .valid_i (v_in),
            .q_o     (stage_data[gi]),
            .valid_o (stage_valid[gi])
        );
    end

    assign Q       = stage_data[DEPTH-1];
    assign Qn      = ~Q;
    assign Q_valid = stage_valid[DEPTH-1];

`ifdef REG_PIPELINE_OCCUPANCY_EN
    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] occ_q, occ_d;

    // Incremental popcount: one word enters and one leaves per enabled edge.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            if (D_valid && !stage_valid[DEPTH-1]) begin
                occ_d = occ_q + OW'(1);
            end else if (!D_valid && stage_valid[DEPTH-1]) begin
                occ_d = occ_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed and randomised checks of reg_pipeline (DEPTH=4 and DEPTH=1 instances).
module tb_reg_pipeline;

    logic       clk = 1'b0;
    logic       rst, en, flush, D_valid;
    logic [7:0] D, Q, Qn;
    logic       Q_valid;
    logic       en1, D1, Dv1, Q1, Qn1, Qv1;
`ifdef REG_PIPELINE_OCCUPANCY_EN
    logic [2:0] occ;
    logic [0:0] occ1;
`endif

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
`ifdef REG_PIPELINE_OCCUPANCY_EN
        .occupancy (occ),
`endif
        .clk (clk), .rst (rst), .en (en), .flush (flush),
        .D (D), .D_valid (D_valid), .Q (Q), .Qn (Qn), .Q_valid (Q_valid)
    );

    reg_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
`ifdef REG_PIPELINE_OCCUPANCY_EN
        .occupancy (occ1),
`endif
        .clk (clk), .rst (rst), .en (en1), .flush (flush),
        .D (D1), .D_valid (Dv1), .Q (Q1), .Qn (Qn1), .Q_valid (Qv1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b en=%b flush=%b D=%h Dv=%b -> Q=%h Qn=%h Qv=%b | d1: en=%b D=%b Dv=%b -> Q=%b Qv=%b",
                 $time, rst, en, flush, D, D_valid, Q, Qn, Q_valid, en1, D1, Dv1, Q1, Qv1);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; D = 8'hFF; D_valid = 1'b1;
        en1 = 1'b1; D1 = 1'b1; Dv1 = 1'b1;
        tick();
        tick();
        assert_cnt++; if (Q !== 8'hA5) begin fail_cnt++; $display("FAIL reset_Q: got %h expected a5", Q); end
        assert_cnt++; if (Qn !== 8'h5A) begin fail_cnt++; $display("FAIL reset_Qn: got %h expected 5a", Qn); end
        assert_cnt++; if (Q_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_Qv: got %b expected 0", Q_valid); end
        assert_cnt++; if ({Q1, Qn1, Qv1} !== 3'b010) begin fail_cnt++; $display("FAIL reset_d1: got Q=%b Qn=%b Qv=%b expected 0 1 0", Q1, Qn1, Qv1); end
`ifdef REG_PIPELINE_OCCUPANCY_EN
        assert_cnt++; if (occ !== 3'd0) begin fail_cnt++; $display("FAIL reset_occ: got %0d expected 0", occ); end
`endif
        rst = 1'b0; en = 1'b0; en1 = 1'b0; D_valid = 1'b1; D = 8'h77;
        tick();
        assert_cnt++; if (Q !== 8'hA5 || Q_valid !== 1'b0) begin fail_cnt++; $display("FAIL hold_after_reset: got Q=%h Qv=%b expected a5 0", Q, Q_valid); end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_q;
        en = 1'b1; D_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            D = 8'(i + 1);
            tick();
            exp_q = (i >= 3) ? 8'(i - 2) : 8'hA5;
            assert_cnt++;
            if (Q !== exp_q || Qn !== ~exp_q || Q_valid !== (i >= 3)) begin
                fail_cnt++;
                $display("FAIL stream[%0d]: got Q=%h Qn=%h Qv=%b expected Q=%h Qn=%h Qv=%b", i, Q, Qn, Q_valid, exp_q, ~exp_q, (i >= 3));
            end
`ifdef REG_PIPELINE_OCCUPANCY_EN
            assert_cnt++;
            if (occ !== 3'((i + 1 > 4) ? 4 : i + 1)) begin
                fail_cnt++; $display("FAIL stream_occ[%0d]: got %0d expected %0d", i, occ, (i + 1 > 4) ? 4 : i + 1);
            end
`endif
        end
    endtask

    task automatic test_stall();
        logic [7:0] d_vec  [7] = '{8'h11, 8'h22, 8'hEE, 8'hEE, 8'hEE, 8'h33, 8'h44};
        logic       en_vec [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_q  [7] = '{8'h0A, 8'h0B, 8'h0B, 8'h0B, 8'h0B, 8'h0C, 8'h11};
        D_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            D = d_vec[i]; en = en_vec[i];
            tick();
            assert_cnt++;
            if (Q !== exp_q[i] || Qn !== ~exp_q[i] || Q_valid !== 1'b1) begin
                fail_cnt++;
                $display("FAIL stall[%0d]: got Q=%h Qn=%h Qv=%b expected Q=%h Qv=1", i, Q, Qn, Q_valid, exp_q[i]);
            end
`ifdef REG_PIPELINE_OCCUPANCY_EN
            assert_cnt++; if (occ !== 3'd4) begin fail_cnt++; $display("FAIL stall_occ[%0d]: got %0d expected 4", i, occ); end
`endif
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_q [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        en = 1'b1; flush = 1'b1; D = 8'h55; D_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            flush = 1'b0; D = 8'h66; D_valid = 1'b0;
            assert_cnt++;
            if (Q !== exp_q[i] || Qn !== ~exp_q[i] || Q_valid !== 1'b0) begin
                fail_cnt++;
                $display("FAIL flush[%0d]: got Q=%h Qn=%h Qv=%b expected Q=%h Qv=0", i, Q, Qn, Q_valid, exp_q[i]);
            end
`ifdef REG_PIPELINE_OCCUPANCY_EN
            assert_cnt++; if (occ !== 3'd0) begin fail_cnt++; $display("FAIL flush_occ[%0d]: got %0d expected 0", i, occ); end
`endif
        end
    endtask

    task automatic test_bubbles();
        logic       pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_q;
        logic       exp_v;
        int         exp_occ;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            D = 8'(8'h70 + i); D_valid = pat[i];
            tick();
            exp_q = (i >= 3) ? 8'(8'h70 + i - 3) : 8'h66;
            exp_v = (i >= 3) ? pat[i-3] : 1'b0;
            assert_cnt++;
            if (Q !== exp_q || Qn !== ~exp_q || Q_valid !== exp_v) begin
                fail_cnt++;
                $display("FAIL bubble[%0d]: got Q=%h Qn=%h Qv=%b expected Q=%h Qv=%b", i, Q, Qn, Q_valid, exp_q, exp_v);
            end
            exp_occ = 0;
            for (int j = (i >= 3) ? i - 3 : 0; j <= i; j++) exp_occ += int'(pat[j]);
`ifdef REG_PIPELINE_OCCUPANCY_EN
            assert_cnt++; if (occ !== 3'(exp_occ)) begin fail_cnt++; $display("FAIL bubble_occ[%0d]: got %0d expected %0d", i, occ, exp_occ); end
`endif
        end
    endtask

    task automatic test_random();
        logic [7:0] md [4];
        logic       mv [4];
        logic       m1d, m1v;
        int         exp_occ;
        rst = 1'b1; flush = 1'b0;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin md[s] = 8'hA5; mv[s] = 1'b0; end
        m1d = 1'b0; m1v = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en = ($urandom_range(0, 3) != 0); D = 8'($urandom); D_valid = 1'($urandom);
            en1 = 1'($urandom); D1 = 1'($urandom); Dv1 = 1'($urandom);
            if (en) begin
                for (int s = 3; s > 0; s--) begin md[s] = md[s-1]; mv[s] = mv[s-1]; end
                md[0] = D; mv[0] = D_valid;
            end
            if (en1) begin m1d = D1; m1v = Dv1; end
            tick();
            assert_cnt++;
            if (Q !== md[3] || Qn !== ~md[3] || Q_valid !== mv[3]) begin
                fail_cnt++;
                $display("FAIL rand4[%0d]: got Q=%h Qn=%h Qv=%b expected Q=%h Qn=%h Qv=%b", i, Q, Qn, Q_valid, md[3], ~md[3], mv[3]);
            end
            assert_cnt++;
            if (Q1 !== m1d || Qn1 !== ~m1d || Qv1 !== m1v) begin
                fail_cnt++;
                $display("FAIL rand1[%0d]: got Q=%b Qn=%b Qv=%b expected Q=%b Qn=%b Qv=%b", i, Q1, Qn1, Qv1, m1d, ~m1d, m1v);
            end
            exp_occ = int'(mv[0]) + int'(mv[1]) + int'(mv[2]) + int'(mv[3]);
`ifdef REG_PIPELINE_OCCUPANCY_EN
            assert_cnt++; if (occ !== 3'(exp_occ)) begin fail_cnt++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", i, occ, exp_occ); end
            assert_cnt++; if (occ1 !== m1v) begin fail_cnt++; $display("FAIL rand_occ1[%0d]: got %0d expected %0d", i, occ1, m1v); end
`else
            if (exp_occ > 4) begin fail_cnt++; $display("FAIL rand_model[%0d]: occupancy %0d out of range", i, exp_occ); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubbles();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/reg_pipeline.md
# reg_pipeline

Parametrised multi-bit, multi-stage D-register pipeline with clock enable, per-stage valid tracking, synchronous flush and complementary outputs. It generalises the single-bit D flip-flop (D, Q, Qn) to a WIDTH-bit data path delayed by DEPTH clock cycles. It is the standard retiming/delay element between datapath blocks on the single system clock.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  stage enable; 1 = pipeline advances, 0 = all stages hold
- flush  input  1  synchronous clear of all valid bits
- D  input  WIDTH  data into stage 0
- D_valid  input  1  marks D as valid
- Q  output  WIDTH  data of last stage (DEPTH-1)
- Qn  output  WIDTH  bitwise complement of Q
- Q_valid  output  1  valid bit of last stage
- occupancy  output  $clog2(DEPTH+1)  count of valid stages (only with REG_PIPELINE_OCCUPANCY_EN)

One clock; reset is synchronous and active-high.

## Operation
- State: data[0..DEPTH-1] (WIDTH bits each), valid[0..DEPTH-1].
- Priority per edge: rst > flush > en > hold.
- rst=1: all data = RESET_VAL, all valid = 0, occupancy = 0. en/flush/D ignored.
- flush=1 (rst=0): all valid = 0, including the incoming D_valid; data registers follow en as normal (shift if en=1, hold if en=0). Data contents are don't-care while invalid.
- en=1 (rst=0, flush=0): data[0] ← D, valid[0] ← D_valid; data[i] ← data[i-1], valid[i] ← valid[i-1] for i=1..DEPTH-1. The last stage's contents are discarded. There is no backpressure and no overflow condition.
- en=0: all data and valid hold. D and D_valid are ignored.
- Q = data[DEPTH-1], Q_valid = valid[DEPTH-1], both direct register outputs.
- Qn = ~Q, combinational from the register. It is never X after reset.
- DEPTH=1 degenerates to a single enabled D flip-flop with valid.

## Timing
- Latency: D sampled at edge k appears on Q after edge k+DEPTH-1, provided en=1 on all DEPTH edges. Each en=0 edge adds one cycle.
- Throughput: one word per enabled cycle.
- Reset values: Q=RESET_VAL, Qn=~RESET_VAL, Q_valid=0, occupancy=0, all visible in the cycle after the reset edge.
- Reset or flush mid-stream: in-flight words are lost. The first post-release word takes the full DEPTH latency.
- flush and en both high: valids are cleared, and D_valid on that edge is dropped.

## Configuration
- REG_PIPELINE_OCCUPANCY_EN defined: the occupancy port and a registered counter are present.
  - Counter next value = popcount of the next valid vector, computed with the same priority rules.
  - Range 0..DEPTH, never wraps.
  - 0 after rst or flush.
  - With en=1, it increments if D_valid=1 and the exiting valid=0, decrements in the opposite case, and is otherwise unchanged.
- Not defined: no occupancy port and no counter logic. All other behaviour is identical.

## Structure
- Package reg_pipeline_pkg:
  - occupancy width function, clog2 of DEPTH+1
  - default parameter constants (WIDTH=8, DEPTH=4)
- Sub-module reg_stage: one WIDTH-bit data register plus valid bit, with rst/flush/en handling. It is instantiated DEPTH times in a generate loop. Qn and occupancy live in the top level.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5, rst=1 for 2 cycles -> Q=8'hA5, Qn=8'h5A, Q_valid=0, occupancy=0.
- Streaming: en=1, D=8'h01,02,03,… with D_valid=1 on consecutive edges -> Q=8'h01 with Q_valid=1 after 4 edges, then one increment per cycle, Qn always ~Q, occupancy reaches 4 and stays.
- Stall: send 8'h11 and drop en for 3 cycles mid-pipeline -> Q/Q_valid frozen during stall; 8'h11 exits exactly 3 cycles later than unstalled.
- Flush: pipeline full of valid words, flush=1 with en=1 and D_valid=1 for one edge -> Q_valid=0 for the next 4 cycles, occupancy=0, and the word presented on the flush edge never appears.
- Bubbles: D_valid pattern 1,0,1,1 with en=1 -> Q_valid pattern 1,0,1,1 delayed 4 cycles; occupancy tracks popcount of the valid bits each cycle.
- Random: 30 cycles of $random D/D_valid/en, flush=0, against a DEPTH-deep reference queue model -> Q, Qn, Q_valid match each cycle; repeat with DEPTH=1 and WIDTH=1.
